imem_rewrite_queue: RTL and testbench

- Downstream consumer of the core's instruction write-back stream (write enable, PC, randomized instruction).
- Buffers re-randomized instruction words in a small FIFO.
- Drains them into the single instruction-memory write port under a valid/ready handshake.
- Sits between the core top and instruction memory, so that a busy write port never stalls the pipeline.

---
 rtl/imem_rewrite_queue.sv | 110 +++++++++++
 tb/tb_imem_rewrite_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_rewrite_queue.sv
// imem_rewrite_queue
// Buffers re-randomized instruction words coming from the core's write-back
// stream and drains them, oldest first, into the single instruction-memory
// write port under a valid/ready handshake. A busy write port therefore never
// back-pressures the pipeline; when the queue is full and nothing drains, the
// incoming word is dropped and the sticky overflow flag is raised.
//
// Optional feature macro: IMEM_REWRITE_BYPASS_EN
//   When defined, fetch_data is forwarded from the newest pending entry whose
//   address matches fetch_addr, so the core never fetches a stale word that
//   is still waiting in the queue. When undefined, fetch_data is simply
//   fetch_data_raw and no address comparators exist.
module imem_rewrite_queue #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     imem_wr_en,
   output logic [ADDR_W-1:0]        imem_wr_addr,
   output logic [DATA_W-1:0]        imem_wr_data,
   input  logic                     imem_wr_ready,
   input  logic [ADDR_W-1:0]        fetch_addr,
   input  logic [DATA_W-1:0]        fetch_data_raw,
   output logic [DATA_W-1:0]        fetch_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Entry storage; contents are don't-care after reset, so no reset here.
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;
   logic              overflow_q;

   logic              push;
   logic              pop;

   // Status derived purely from the registered occupancy count.
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign count    = count_q;
   assign overflow = overflow_q;

   // A pop in the same cycle frees a slot, so a full queue can still accept.
   assign pop  = !empty && imem_wr_ready;
   assign push = wr_en && (!full || pop);

   // Head entry goes straight to the memory port; forced to zero while empty.
   assign imem_wr_en   = !empty;
   assign imem_wr_addr = empty ? '0 : addr_q[head_q];
   assign imem_wr_data = empty ? '0 : data_q[head_q];

   // Pointer, occupancy and sticky overflow bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (wr_en && !push)    overflow_q <= 1'b1;
      end
   end

   // Capture the incoming word at the tail slot.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= wr_addr;
         data_q[tail_q] <= wr_data;
      end
   end

`ifdef IMEM_REWRITE_BYPASS_EN
   // Walk occupied entries oldest to newest so the newest match wins; the
   // entry being popped this cycle is still occupied, a same-cycle push is not.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fetch_data = fetch_data_raw;
      idx        = head_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (addr_q[idx] == fetch_addr))
            fetch_data = data_q[idx];
      end
   end
`else
   // No forwarding: fetches see memory contents until the write drains.
   logic unused_fetch_addr;
   assign unused_fetch_addr = ^fetch_addr;
   assign fetch_data        = fetch_data_raw;
`endif

endmodule

// File: tb/tb_imem_rewrite_queue.sv
// Bench for imem_rewrite_queue: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the rewrite buffer.
module tb_imem_rewrite_queue;

   localparam int DEPTH = 4;
`ifdef IMEM_REWRITE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        full, empty, overflow;
   logic [2:0]  count;
   logic        imem_wr_en;
   logic [7:0]  imem_wr_addr;
   logic [15:0] imem_wr_data;
   logic        ready = 1'b0;
   logic [7:0]  fetch_addr = '0;
   logic [15:0] fetch_data_raw = '0;
   logic [15:0] fetch_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  a;
      logic [15:0] d;
   } ent_t;
   ent_t q[$];
   bit   m_ovf = 1'b0;

   imem_rewrite_queue #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
      .imem_wr_ready(ready), .fetch_addr(fetch_addr), .fetch_data_raw(fetch_data_raw),
      .fetch_data(fetch_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

   // One clock edge; the model applies the rules to the inputs held at that edge.
   task automatic tick();
      bit p_pop, p_push;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         p_pop  = (q.size() > 0) && ready;
         p_push = wr_en && ((q.size() < DEPTH) || p_pop);
         if (wr_en && !p_push) m_ovf = 1'b1;
         if (p_pop) void'(q.pop_front());
         if (p_push) q.push_back('{wr_addr, wr_data});
      end
      #1;
   endtask

   function automatic logic [15:0] model_fetch(logic [7:0] a, logic [15:0] raw);
      logic [15:0] r;
      r = raw;
      if (BYPASS)
         foreach (q[i]) if (q[i].a == a) r = q[i].d;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1; wr_en = 1; wr_addr = 8'h55; wr_data = 16'h5555;
      tick();
      rst = 0; wr_en = 0;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (imem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", imem_wr_en); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      checks++; if ({imem_wr_addr, imem_wr_data} !== 24'h0) begin errors++; $display("FAIL reset_head got %h/%h want 0/0", imem_wr_addr, imem_wr_data); end
      tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_nostore got empty=%b want 1", empty); end
   endtask

   task automatic test_fill_overflow();
      ready = 0;
      for (int k = 0; k < 5; k++) begin
         wr_en = 1; wr_addr = 8'h10 + 8'(k); wr_data = 16'hA001 + 16'(k);
         tick();
         if (k == 3) begin
            checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fill_full got full=%b ovf=%b want 1 0", full, overflow); end
         end
      end
      wr_en = 0;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
      ready = 1;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (imem_wr_en !== 1'b1 || imem_wr_addr !== 8'h10 + 8'(k) || imem_wr_data !== 16'hA001 + 16'(k)) begin
            errors++; $display("FAIL drain_%0d got %b %h/%h want 1 %h/%h", k, imem_wr_en, imem_wr_addr, imem_wr_data, 8'h10 + 8'(k), 16'hA001 + 16'(k));
         end
         tick();
      end
      checks++; if (empty !== 1'b1 || imem_wr_en !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%b en=%b want 1 0", empty, imem_wr_en); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      rst = 1; tick(); rst = 0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      ready = 0;
      for (int k = 0; k < 4; k++) begin
         wr_en = 1; wr_addr = 8'h50 + 8'(k); wr_data = 16'hC000 + 16'(k);
         tick();
      end
      ready = 1; wr_en = 1; wr_addr = 8'h20; wr_data = 16'hBEEF;
      tick();
      wr_en = 0;
      checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL pushpop_count got %0d full=%b want 4 1", count, full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_ovf got %b want 0", overflow); end
      for (int k = 0; k < 4; k++) begin
         logic [7:0]  ea;
         logic [15:0] ed;
         ea = (k == 3) ? 8'h20 : 8'h51 + 8'(k);
         ed = (k == 3) ? 16'hBEEF : 16'hC001 + 16'(k);
         checks++;
         if (imem_wr_addr !== ea || imem_wr_data !== ed) begin
            errors++; $display("FAIL pushpop_order_%0d got %h/%h want %h/%h", k, imem_wr_addr, imem_wr_data, ea, ed);
         end
         tick();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pushpop_empty got %b want 1", empty); end
   endtask

   task automatic test_latency();
      ready = 1; wr_en = 1; wr_addr = 8'h30; wr_data = 16'h1111;
      #1;
      checks++; if (imem_wr_en !== 1'b0) begin errors++; $display("FAIL lat_nofall got %b want 0", imem_wr_en); end
      tick();
      wr_en = 0;
      checks++;
      if (imem_wr_en !== 1'b1 || imem_wr_addr !== 8'h30 || imem_wr_data !== 16'h1111) begin
         errors++; $display("FAIL lat_present got %b %h/%h want 1 30/1111", imem_wr_en, imem_wr_addr, imem_wr_data);
      end
      tick();
      checks++; if (empty !== 1'b1 || imem_wr_en !== 1'b0) begin errors++; $display("FAIL lat_empty got empty=%b en=%b want 1 0", empty, imem_wr_en); end
   endtask

   task automatic test_bypass();
      logic [15:0] exp;
      ready = 0;
      wr_en = 1; wr_addr = 8'h40; wr_data = 16'h1234; tick();
      wr_addr = 8'h40; wr_data = 16'h5678; tick();
      wr_en = 0; fetch_addr = 8'h40; fetch_data_raw = 16'h0000;
      #1;
      exp = BYPASS ? 16'h5678 : 16'h0000;
      checks++; if (fetch_data !== exp) begin errors++; $display("FAIL byp_newest got %h want %h", fetch_data, exp); end
      fetch_addr = 8'h41;
      #1;
      checks++; if (fetch_data !== 16'h0000) begin errors++; $display("FAIL byp_miss got %h want 0000", fetch_data); end
      wr_en = 1; wr_addr = 8'h41; wr_data = 16'h9999;
      #1;
      checks++; if (fetch_data !== 16'h0000) begin errors++; $display("FAIL byp_samepush got %h want 0000", fetch_data); end
      tick();
      wr_en = 0;
      exp = BYPASS ? 16'h9999 : 16'h0000;
      checks++; if (fetch_data !== exp) begin errors++; $display("FAIL byp_nextcycle got %h want %h", fetch_data, exp); end
      ready = 1; tick();
      fetch_addr = 8'h40;
      #1;
      exp = BYPASS ? 16'h5678 : 16'h0000;
      checks++; if (fetch_data !== exp) begin errors++; $display("FAIL byp_popping got %h want %h", fetch_data, exp); end
      tick(); tick();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL byp_drain got %b want 1", empty); end
   endtask

   task automatic test_reset_mid_drain();
      ready = 0;
      for (int k = 0; k < 3; k++) begin
         wr_en = 1; wr_addr = 8'h70 + 8'(k); wr_data = 16'hD000 + 16'(k);
         tick();
      end
      wr_en = 0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
      rst = 1; tick(); rst = 0;
      checks++; if (empty !== 1'b1 || imem_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset got empty=%b en=%b want 1 0", empty, imem_wr_en); end
      ready = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (imem_wr_en !== 1'b0) begin errors++; $display("FAIL mid_nowrite_%0d got %b want 0", k, imem_wr_en); end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [15:0] ef;
         rst            = ($urandom_range(0, 59) == 0);
         wr_en          = ($urandom_range(0, 99) < 60);
         wr_addr        = 8'h60 + 8'($urandom_range(0, 3));
         wr_data        = 16'($urandom);
         ready          = ($urandom_range(0, 99) < 45);
         fetch_addr     = 8'h60 + 8'($urandom_range(0, 4));
         fetch_data_raw = 16'($urandom);
         #1;
         ef = model_fetch(fetch_addr, fetch_data_raw);
         checks++;
         if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || overflow !== m_ovf) begin
            errors++; $display("FAIL rnd_status_%0d got cnt=%0d e=%b f=%b o=%b want cnt=%0d o=%b", n, count, empty, full, overflow, q.size(), m_ovf);
         end
         checks++;
         if (q.size() == 0) begin
            if (imem_wr_en !== 1'b0 || imem_wr_addr !== 8'h0 || imem_wr_data !== 16'h0) begin
               errors++; $display("FAIL rnd_head_%0d got %b %h/%h want 0 00/0000", n, imem_wr_en, imem_wr_addr, imem_wr_data);
            end
         end else if (imem_wr_en !== 1'b1 || imem_wr_addr !== q[0].a || imem_wr_data !== q[0].d) begin
            errors++; $display("FAIL rnd_head_%0d got %b %h/%h want 1 %h/%h", n, imem_wr_en, imem_wr_addr, imem_wr_data, q[0].a, q[0].d);
         end
         checks++; if (fetch_data !== ef) begin errors++; $display("FAIL rnd_fetch_%0d got %h want %h", n, fetch_data, ef); end
         tick();
      end
      rst = 0; wr_en = 0; ready = 0;
   endtask

   initial begin
      #2;
      test_reset();
      test_fill_overflow();
      test_full_push_pop();
      test_latency();
      test_bypass();
      test_reset_mid_drain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
